// File: rtl/crc_serial_engine_if.sv
// Ready/valid bundle for crc_serial_engine: word in, {data, crc} out.
// Carries crc_in/crc_err only when CRC_CHECK_EN is defined.
interface crc_serial_engine_if #(
  parameter int DATA_W = 48,
  parameter int CRC_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        data_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [CRC_W-1:0]         crc_out;
  logic [DATA_W+CRC_W-1:0]  data_out;
`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0]         crc_in;
  logic                     crc_err;
`endif

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, crc_out,
`ifdef CRC_CHECK_EN
    output crc_in,
    input  crc_err,
    input  data_out
`else
    input  data_out
`endif
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, crc_out,
`ifdef CRC_CHECK_EN
    input  crc_in,
    output crc_err,
    output data_out
`else
    output data_out
`endif
  );
endinterface

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator: one DATA_W word per handshake, MSB-first LFSR, one bit/clock.
// Optional CRC_CHECK_EN macro adds compare of the result against a captured crc_in.
module crc_serial_engine #(
  parameter int               DATA_W  = 48,
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h31),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  crc_serial_engine_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CRC_W-1:0]        crc_out_q, crc_out_d;
  logic [DATA_W+CRC_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [CRC_W-1:0]        crc_q, crc_d;
  logic [CRC_W-1:0]        crc_next;
  logic [CRC_W-1:0]        crc_fin;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic             b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  assign crc_next = crc_step(crc_q, shift_q[DATA_W-1]);
  assign crc_fin  = crc_next ^ XOR_OUT;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    crc_out_d  = crc_out_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          hold_d  = bus.data_in;
          shift_d = bus.data_in;
          crc_d   = INIT;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        crc_d   = crc_next;
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
          // Last bit consumed this edge: publish the finished frame.
          state_d    = DONE;
          crc_out_d  = crc_fin;
          data_out_d = {hold_q, crc_fin};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Control and visible outputs: cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      crc_out_q   <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      crc_out_q   <= crc_out_d;
      data_out_q  <= data_out_d;
    end
  end

  // Working datapath: always reloaded at accept, so no reset needed.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
    crc_q   <= crc_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.data_out  = data_out_q;

`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0] crc_exp_q;

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_valid && in_ready_q) crc_exp_q <= bus.crc_in;
  end

  assign bus.crc_err = out_valid_q && (crc_out_q != crc_exp_q);
`else
`endif
endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: default 48+8 instance and a CRC-16 byte instance.
module tb_crc_serial_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [55:0] dout;
    logic [7:0]  crc;
  } exp_t;
  exp_t sb[$];

  crc_serial_engine_if #(.DATA_W(48), .CRC_W(8))  bus ();
  crc_serial_engine_if #(.DATA_W(8),  .CRC_W(16)) bus16 ();

  crc_serial_engine dut0 (.clk(clk), .rst_n(rst_n), .bus(bus));
  crc_serial_engine #(
    .DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  // Remainder of (d * x^8) mod (x^8+x^5+x^4+1) by long division.
  function automatic logic [7:0] crc_ref(input logic [47:0] d);
    logic [55:0] r;
    r = {d, 8'h00};
    for (int i = 55; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h131;
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [47:0] d);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_wait", 64'(n < 200), 64'd1);
    bus.data_in  = d;
    bus.in_valid = 1'b1;
    sb.push_back('{dout: {d, crc_ref(d)}, crc: crc_ref(d)});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ovld(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic recv0(input string tag, input int lat);
    int   n;
    exp_t e;
    wait_ovld(n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    chk({tag, "_crc"},  64'(bus.crc_out),  64'(e.crc));
    chk({tag, "_data"}, 64'(bus.data_out), 64'(e.dout));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_ovld_clr"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_rdy_back"}, 64'(bus.in_ready),  64'd1);
    chk({tag, "_hold"},     64'(bus.data_out),  64'(e.dout));
  endtask

  initial begin
    int          n;
    logic [47:0] w;
    bus.in_valid    = 1'b0;
    bus.data_in     = '0;
    bus.out_ready   = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.data_in   = '0;
    bus16.out_ready = 1'b0;
`ifdef CRC_CHECK_EN
    bus.crc_in   = '0;
    bus16.crc_in = '0;
`endif

    // Reset state
    #12;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_crc_out",   64'(bus.crc_out),   64'd0);
    chk("rst_data_out",  64'(bus.data_out),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

    // Zero word, then 1 and 2
    send0(48'h0);
    recv0("zero", 48);
    chk("zero_const", 64'(bus.data_out), 64'h0);
    send0(48'h1);
    recv0("one", 48);
    chk("one_const", 64'(bus.data_out), {8'h00, 48'h1, 8'h31});
    send0(48'h2);
    recv0("two", 48);
    chk("two_const", 64'(bus.crc_out), 64'h62);

    // Patterned and random words
    send0(48'hFFFF_FFFF_FFFF);
    recv0("ones", 48);
    send0(48'h8000_0000_0000);
    recv0("msb", 48);
    for (int k = 0; k < 3; k++) begin
      w = {16'($urandom), 32'($urandom)};
      send0(w);
      recv0("rand", 48);
    end

    // Stall in DONE with a competing in_valid
    send0(48'hA5A5_0000_1234);
    wait_ovld(n);
    chk("stall_lat", 64'(n), 64'd48);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin bus.in_valid = 1'b1; bus.data_in = 48'hDEAD_BEEF_0000; end
      @(negedge clk);
      chk("stall_ovld",  64'(bus.out_valid), 64'd1);
      chk("stall_rdy",   64'(bus.in_ready),  64'd0);
      chk("stall_data",  64'(bus.data_out),  64'(sb[0].dout));
      chk("stall_crc",   64'(bus.crc_out),   64'(sb[0].crc));
    end
    bus.in_valid = 1'b0;
    recv0("stall", 0);
    repeat (60) @(negedge clk);
    chk("ignored_word", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-SHIFT
    send0(48'h1234_5678_9ABC);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ovld", 64'(bus.out_valid), 64'd0);
    chk("midrst_rdy",  64'(bus.in_ready),  64'd0);
    chk("midrst_crc",  64'(bus.crc_out),   64'd0);
    chk("midrst_data", 64'(bus.data_out),  64'd0);
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send0(48'h1);
    recv0("after_rst", 48);
    chk("after_rst_const", 64'(bus.crc_out), 64'h31);

    // CRC-16 instance, INIT=FFFF, byte 0x31
    bus16.data_in  = 8'h31;
    bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    n = 0;
    while (bus16.out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("c16_lat",  64'(n), 64'd8);
    chk("c16_crc",  64'(bus16.crc_out),  64'hC782);
    chk("c16_data", 64'(bus16.data_out), 64'h31C782);
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    chk("c16_pop", 64'(bus16.out_valid), 64'd0);

`ifdef CRC_CHECK_EN
    // Received-CRC compare
    chk("err_idle", 64'(bus.crc_err), 64'd0);
    bus.crc_in = 8'h31;
    send0(48'h1);
    wait_ovld(n);
    chk("err_match", 64'(bus.crc_err), 64'd0);
    recv0("chk_ok", 0);
    bus.crc_in = 8'h30;
    send0(48'h1);
    wait_ovld(n);
    chk("err_mismatch", 64'(bus.crc_err), 64'd1);
    recv0("chk_bad", 0);
    chk("err_after_pop", 64'(bus.crc_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
